unsat_clause_buffer: RTL and testbench

- Upstream neighbour of clause_register.
- Collects unsatisfied clauses (3 literals x 12-bit index = 36 bits) pushed by the clause evaluator.
- Serves them one at a time to up to 4 clause_register instances via a round-robin req/gnt handshake.
- Drives reg_en/reg_in/count in the format clause_register consumes.

---
 rtl/unsat_clause_buffer.sv | 172 +++++++++++++++++
 tb/tb_unsat_clause_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/unsat_clause_buffer.sv
// unsat_clause_buffer: collects unsatisfied clauses from the evaluator and
// serves them one per cycle to up to NREQ clause_register instances via a
// round-robin req/gnt handshake.
// Build option: define UCB_RANDOM_PICK_EN to replace FIFO order with an
// LFSR-driven random pick from a compacted slot array (WalkSAT selection).
module unsat_clause_buffer #(
  parameter int          WIDTH     = 36,
  parameter int          DEPTH     = 16,
  parameter int          CNT_W     = 5,
  parameter int          NREQ      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_clause,
  output logic             push_ready,
  output logic             overflow,
  input  logic [NREQ:1]    ucb_req,
  output logic [NREQ:1]    ucb_gnt,
  output logic             reg_en,
  output logic [WIDTH-1:0] reg_in,
  output logic [CNT_W-1:0] count
);

  localparam int RR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             reg_en_reg;
  logic [WIDTH-1:0] reg_in_reg;
  logic             overflow_reg;
  logic [RR_W-1:0]  rr_ptr_reg;
  logic [RR_W-1:0]  rr_ptr_next;

  logic [NREQ-1:0]  req_vec;
  logic [NREQ-1:0]  pick_onehot;
  logic [RR_W-1:0]  pick_idx;
  logic             pick_found;
  logic             push_acc;
  logic             pop;
  logic [WIDTH-1:0] pop_data;

  logic [WIDTH-1:0] mem [DEPTH];

  // Re-index the 1-based request port to a 0-based vector
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_vec[gi]   = ucb_req[gi+1];
      assign ucb_gnt[gi+1] = gnt_reg[gi];
    end
  endgenerate

  assign push_ready = (count_reg < CNT_W'(DEPTH));
  assign overflow   = overflow_reg;
  assign reg_en     = reg_en_reg;
  assign reg_in     = reg_in_reg;
  assign count      = count_reg;

  // Round-robin search: first requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    idx         = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req_vec[RR_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = RR_W'(idx);
      end
    end
    if (pick_found) pick_onehot[pick_idx] = 1'b1;
    rr_ptr_next = (pick_idx == RR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Push uses the registered count, so a full buffer refuses even when popping
  assign push_acc = push_valid && push_ready && !flush;
  assign pop      = pick_found && (count_reg != '0) && !flush;

`ifdef UCB_RANDOM_PICK_EN
  logic [15:0]      lfsr_reg;
  logic [CNT_W-1:0] lfsr_low;
  logic [CNT_W-1:0] rand_full;
  logic [CNT_W-1:0] last_full;
  logic [PTR_W-1:0] rand_slot;
  logic [PTR_W-1:0] last_slot;
  logic [PTR_W-1:0] tail_slot;

  assign lfsr_low  = CNT_W'(lfsr_reg[3:0]);
  assign rand_full = (count_reg == '0) ? '0 : (lfsr_low % count_reg);
  assign last_full = count_reg - 1'b1;
  assign rand_slot = rand_full[PTR_W-1:0];
  assign last_slot = last_full[PTR_W-1:0];
  assign tail_slot = count_reg[PTR_W-1:0];
  assign pop_data  = mem[rand_slot];

  // Fibonacci LFSR (taps 16,14,13,11) free-running every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_reg <= LFSR_SEED;
    else     lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  // Compacted storage: pops fill the hole from the tail, or from the new push
  always_ff @(posedge clk) begin
    if (push_acc && pop) begin
      mem[rand_slot] <= push_clause;
    end else begin
      if (push_acc) mem[tail_slot] <= push_clause;
      if (pop)      mem[rand_slot] <= mem[last_slot];
    end
  end
`else
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             unused_seed;

  assign unused_seed = ^LFSR_SEED;
  assign pop_data    = mem[rd_ptr_reg];

  // Circular FIFO pointers, wrapping at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_acc) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_reg] <= push_clause;
  end
`endif

  // Occupancy, grant pulse, popped word, overflow flag and rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      gnt_reg      <= '0;
      reg_en_reg   <= 1'b0;
      reg_in_reg   <= '0;
      overflow_reg <= 1'b0;
      rr_ptr_reg   <= '0;
    end else if (flush) begin
      count_reg    <= '0;
      gnt_reg      <= '0;
      reg_en_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg  <= count_reg + CNT_W'(push_acc) - CNT_W'(pop);
      gnt_reg    <= pop ? pick_onehot : '0;
      reg_en_reg <= pop;
      if (pop) begin
        reg_in_reg <= pop_data;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (push_valid && !push_ready) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unsat_clause_buffer.sv
// Scoreboard bench for unsat_clause_buffer: directed stimulus pushes the
// expected grant/clause pairs, a negedge monitor pops and compares them.
module tb_unsat_clause_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic [35:0] push_clause;
  logic        push_ready;
  logic        overflow;
  logic [4:1]  ucb_req;
  logic [4:1]  ucb_gnt;
  logic        reg_en;
  logic [35:0] reg_in;
  logic [4:0]  count;

  typedef struct {
    logic [4:1]  gnt;
    logic [35:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  unsat_clause_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_clause(push_clause),
    .push_ready (push_ready),
    .overflow   (overflow),
    .ucb_req    (ucb_req),
    .ucb_gnt    (ucb_gnt),
    .reg_en     (reg_en),
    .reg_in     (reg_in),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] c);
    push_valid  = 1'b1;
    push_clause = c;
    step();
    push_valid  = 1'b0;
  endtask

  task automatic expect_grant(input logic [4:1] g, input logic [35:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented reg_en must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (reg_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {60'd0, ucb_gnt}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_gnt", {60'd0, ucb_gnt}, {60'd0, e.gnt});
          check("grant_data", {28'd0, reg_in}, {28'd0, e.data});
        end
      end else if (ucb_gnt != 4'b0000) begin
        check("gnt_without_reg_en", {60'd0, ucb_gnt}, 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_clause = '0; ucb_req = '0;
    repeat (2) step();
    check("reset_count", {59'd0, count}, 64'd0);
    check("reset_gnt", {60'd0, ucb_gnt}, 64'd0);
    check("reset_reg_en", {63'd0, reg_en}, 64'd0);
    check("reset_reg_in", {28'd0, reg_in}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_push_ready", {63'd0, push_ready}, 64'd1);
    rst = 1'b0;
    step();

    // FIFO order to a single requester
    push(36'h001_002_003);
    push(36'h004_005_006);
    push(36'h007_008_009);
    check("fifo_count3", {59'd0, count}, 64'd3);
    ucb_req = 4'b1000;
    expect_grant(4'b1000, 36'h001_002_003);
    step(); check("fifo_count2", {59'd0, count}, 64'd2);
    expect_grant(4'b1000, 36'h004_005_006);
    step(); check("fifo_count1", {59'd0, count}, 64'd1);
    expect_grant(4'b1000, 36'h007_008_009);
    step(); check("fifo_count0", {59'd0, count}, 64'd0);
    step(); check("empty_no_gnt", {60'd0, ucb_gnt}, 64'd0);
    ucb_req = 4'b0000;

    // Round-robin rotation with all requesters held
    push(36'h00A_00B_00C);
    push(36'h00D_00E_00F);
    ucb_req = 4'b1111;
    expect_grant(4'b0001, 36'h00A_00B_00C);
    step();
    expect_grant(4'b0010, 36'h00D_00E_00F);
    step(); check("rr_count0", {59'd0, count}, 64'd0);
    step(); check("rr_empty_no_gnt", {60'd0, ucb_gnt}, 64'd0);
    ucb_req = 4'b0000;
    push(36'h011_012_013);
    push(36'h014_015_016);
    push(36'h017_018_019);
    ucb_req = 4'b1111;
    expect_grant(4'b0100, 36'h011_012_013);
    step();
    expect_grant(4'b1000, 36'h014_015_016);
    step();
    expect_grant(4'b0001, 36'h017_018_019);
    step();
    ucb_req = 4'b0000;
    step(); check("rr_drained", {59'd0, count}, 64'd0);

    // Fill to DEPTH, overflow on the 17th, then flush
    for (int i = 0; i < 16; i++) push(36'h100 + 36'(i));
    check("full_count", {59'd0, count}, 64'd16);
    check("full_push_ready", {63'd0, push_ready}, 64'd0);
    push(36'hBAD_BAD_BAD);
    check("ovf_count", {59'd0, count}, 64'd16);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", {59'd0, count}, 64'd0);
    check("flush_overflow", {63'd0, overflow}, 64'd0);
    check("flush_push_ready", {63'd0, push_ready}, 64'd1);

    // Full + pop + push in the same cycle: push refused
    for (int i = 0; i < 16; i++) push(36'h200 + 36'(i));
    push_valid  = 1'b1;
    push_clause = 36'h2FF;
    ucb_req     = 4'b0001;
    expect_grant(4'b0001, 36'h200);
    step();
    ucb_req = 4'b0000;
    check("fullpop_count", {59'd0, count}, 64'd15);
    check("fullpop_overflow", {63'd0, overflow}, 64'd1);
    step();
    push_valid = 1'b0;
    check("refill_count", {59'd0, count}, 64'd16);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Empty + push + request: grant only on the following edge
    push_valid  = 1'b1;
    push_clause = 36'h0AA_0BB_0CC;
    ucb_req     = 4'b0100;
    step();
    push_valid = 1'b0;
    check("emptypush_no_gnt", {60'd0, ucb_gnt}, 64'd0);
    check("emptypush_count", {59'd0, count}, 64'd1);
    expect_grant(4'b0100, 36'h0AA_0BB_0CC);
    step();
    ucb_req = 4'b0000;
    check("emptypush_count0", {59'd0, count}, 64'd0);

    // Asynchronous reset during a grant cycle
    push(36'h0C1_0C2_0C3);
    push(36'h0C4_0C5_0C6);
    ucb_req = 4'b0010;
    expect_grant(4'b0010, 36'h0C1_0C2_0C3);
    step();
    ucb_req = 4'b0000;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", {60'd0, ucb_gnt}, 64'd0);
    check("async_rst_reg_en", {63'd0, reg_en}, 64'd0);
    check("async_rst_count", {59'd0, count}, 64'd0);
    step();
    rst = 1'b0;
    step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
